// File: rtl/run_det_pkg.sv
// Shared types and helpers for the run_det_sched scheduler and its run-detector core.
package run_det_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SHIFT  = 2'd2,
      REPORT = 2'd3
   } state_t;

   localparam int RUN_LEN_DEF = 4;

   // Index width for n items, never narrower than one bit.
   function automatic int clog2w(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/run_det_sched_if.sv
// Requester-side bus of run_det_sched: requests and job words in, grant and job report out.
interface run_det_sched_if
   import run_det_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8
);

   localparam int IDW = clog2w(NREQ);
   localparam int PW  = clog2w(DATA_W);

   logic [NREQ-1:0]        req;
   logic [NREQ*DATA_W-1:0] data;
   logic [NREQ-1:0]        gnt;
   logic                   busy;
   logic                   done;
   logic [IDW-1:0]         done_id;
   logic                   hit;
   logic [PW-1:0]          hit_pos;

   modport master (
      output req, data,
      input  gnt, busy, done, done_id, hit, hit_pos
   );

   modport slave (
      input  req, data,
      output gnt, busy, done, done_id, hit, hit_pos
   );

endinterface

// File: rtl/run_det_core.sv
// Serial run-of-ones counter; hit_now flags the bit on which RUN_LEN consecutive 1s complete.
module run_det_core
   import run_det_pkg::*;
#(
   parameter int RUN_LEN = RUN_LEN_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic bit_in,
   output logic hit_now
);

   localparam int CW = clog2w(RUN_LEN + 1);
   localparam logic [CW-1:0] SAT = CW'(RUN_LEN);

   logic [CW-1:0] run_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         run_cnt <= '0;
      end else if (clr) begin
         run_cnt <= '0;
      end else if (en) begin
         if (!bit_in)
            run_cnt <= '0;
         else if (run_cnt != SAT)
            run_cnt <= run_cnt + 1'b1;
      end
   end

   // Count already at RUN_LEN-1 (or saturated) plus this 1 completes a run.
   assign hit_now = en && bit_in && (run_cnt >= (SAT - 1'b1));

endmodule

// File: rtl/run_det_sched.sv
// Round-robin scheduler feeding one shared run-of-ones detector, LSB first.
// Optional macro RUN_DET_EARLY_EXIT_EN ends a job on the cycle after its first hit.
module run_det_sched
   import run_det_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DATA_W  = 8,
   parameter int RUN_LEN = RUN_LEN_DEF
) (
   input  logic          clk,
   input  logic          reset,
   run_det_sched_if.slave bus
);

   localparam int IDW = clog2w(NREQ);
   localparam int PW  = clog2w(DATA_W);
   localparam logic [PW-1:0] LAST_BIT = PW'(DATA_W - 1);

   state_t              state;
   logic [IDW-1:0]      ptr;
   logic [IDW-1:0]      winner;
   logic [IDW-1:0]      pick;
   logic                found;
   logic [DATA_W-1:0]   shift_reg;
   logic [PW-1:0]       bit_cnt;
   logic                hit_now;
   logic                first_hit;
   logic                last_bit;

   logic [NREQ-1:0]     gnt;
   logic                busy;
   logic                done;
   logic [IDW-1:0]      done_id;
   logic                hit;
   logic [PW-1:0]       hit_pos;

   assign bus.gnt     = gnt;
   assign bus.busy    = busy;
   assign bus.done    = done;
   assign bus.done_id = done_id;
   assign bus.hit     = hit;
   assign bus.hit_pos = hit_pos;

   // Lowest set request overall, overridden by the lowest one above the pointer.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            found = 1'b1;
            pick  = IDW'(i);
         end
      end
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req[i] && (IDW'(i) > ptr)) pick = IDW'(i);
      end
   end

   run_det_core #(.RUN_LEN(RUN_LEN)) u_core (
      .clk     (clk),
      .reset   (reset),
      .clr     (state == LOAD),
      .en      (state == SHIFT),
      .bit_in  (shift_reg[0]),
      .hit_now (hit_now)
   );

   assign first_hit = hit_now && !hit;
`ifdef RUN_DET_EARLY_EXIT_EN
   assign last_bit  = (bit_cnt == LAST_BIT) || first_hit;
`else
   assign last_bit  = (bit_cnt == LAST_BIT);
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         ptr       <= IDW'(NREQ - 1);
         winner    <= '0;
         shift_reg <= '0;
         bit_cnt   <= '0;
         gnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         done_id   <= '0;
         hit       <= 1'b0;
         hit_pos   <= '0;
      end else begin
         gnt  <= '0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  winner <= pick;
                  gnt    <= NREQ'(1) << pick;
                  busy   <= 1'b1;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               shift_reg <= bus.data[int'(winner) * DATA_W +: DATA_W];
               bit_cnt   <= '0;
               hit       <= 1'b0;
               hit_pos   <= '0;
               state     <= SHIFT;
            end
            SHIFT: begin
               shift_reg <= shift_reg >> 1;
               bit_cnt   <= bit_cnt + 1'b1;
               if (first_hit) begin
                  hit     <= 1'b1;
                  hit_pos <= bit_cnt;
               end
               if (last_bit) begin
                  done    <= 1'b1;
                  done_id <= winner;
                  state   <= REPORT;
               end
            end
            REPORT: begin
               ptr   <= winner;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_run_det_sched.sv
// Self-checking bench for run_det_sched: vector table, random jobs vs. a word-level model, corner sequences.
module tb_run_det_sched;

   localparam int NREQ    = 4;
   localparam int DATA_W  = 8;
   localparam int RUN_LEN = 4;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   mptr;

   run_det_sched_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

   run_det_sched #(.NREQ(NREQ), .DATA_W(DATA_W), .RUN_LEN(RUN_LEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [NREQ-1:0]        req;
      logic [NREQ*DATA_W-1:0] data;
      int                     exp_id;
      logic                   exp_hit;
      int                     exp_pos;
   } vec_t;

   vec_t vecs[7];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Word-level reference: scan bits LSB first, note where the first run of RUN_LEN ones ends.
   function automatic void refRun(input logic [DATA_W-1:0] w, output logic h, output int pos);
      int run;
      run = 0;
      h   = 1'b0;
      pos = 0;
      for (int i = 0; i < DATA_W; i++) begin
         run = w[i] ? run + 1 : 0;
         if (run >= RUN_LEN && !h) begin
            h   = 1'b1;
            pos = i;
         end
      end
   endfunction

   function automatic int expLat(input logic h, input int pos);
`ifdef RUN_DET_EARLY_EXIT_EN
      return h ? 3 + pos : 2 + DATA_W;
`else
      return 2 + DATA_W;
`endif
   endfunction

   function automatic int modelPick(input logic [NREQ-1:0] r, input int p);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic doReset();
      reset = 1'b0;
      bus.req = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      mptr = NREQ - 1;
   endtask

   // One job from an idle DUT: grant one cycle after the request, done exactly expLat cycles after.
   task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*DATA_W-1:0] d,
                                input int exp_id, input logic exp_hit, input int exp_pos);
      int lat;
      int waited;
      lat = expLat(exp_hit, exp_pos);
      waited = 0;
      while (bus.busy && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("idle_before_job", 32'(bus.busy), 32'd0);
      bus.req  = r;
      bus.data = d;
      for (int k = 1; k <= lat + 2; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checkOutput("gnt", 32'(bus.gnt), 32'(1) << exp_id);
            checkOutput("busy_at_gnt", 32'(bus.busy), 32'd1);
            bus.req = '0;
         end else if (bus.gnt != '0) begin
            checkOutput("gnt_stray", 32'(bus.gnt), 32'd0);
         end
         if (k == lat) begin
            checkOutput("done_at_latency", 32'(bus.done), 32'd1);
            checkOutput("done_id", 32'(bus.done_id), 32'(exp_id));
            checkOutput("hit", 32'(bus.hit), 32'(exp_hit));
            checkOutput("hit_pos", 32'(bus.hit_pos), 32'(exp_pos));
         end else if (bus.done) begin
            checkOutput("done_stray", 32'(bus.done), 32'd0);
         end
         if (k == lat + 1) checkOutput("busy_after_report", 32'(bus.busy), 32'd0);
      end
   endtask

   initial begin
      logic [NREQ-1:0]        r;
      logic [NREQ*DATA_W-1:0] d;
      logic                   h;
      int                     pos;
      int                     id;
      int                     dcount;
      logic [NREQ-1:0]        gq[$];
      int                     dq[$];
      logic                   hq[$];
      int                     pq[$];

      checks = 0;
      errors = 0;
      bus.req  = '0;
      bus.data = '0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_gnt", 32'(bus.gnt), 32'd0);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_done", 32'(bus.done), 32'd0);
      checkOutput("reset_done_id", 32'(bus.done_id), 32'd0);
      checkOutput("reset_hit", 32'(bus.hit), 32'd0);
      checkOutput("reset_hit_pos", 32'(bus.hit_pos), 32'd0);
      doReset();

      vecs[0] = '{4'b0001, 32'h0000000F, 0, 1'b1, 3};
      vecs[1] = '{4'b0001, 32'h000000EE, 0, 1'b0, 0};
      vecs[2] = '{4'b0001, 32'h000000FF, 0, 1'b1, 3};
      vecs[3] = '{4'b0110, 32'hFFFFF000, 1, 1'b1, 7};
      vecs[4] = '{4'b0110, 32'h0078FFFF, 2, 1'b1, 6};
      vecs[5] = '{4'b1001, 32'h0100FFFF, 3, 1'b0, 0};
      vecs[6] = '{4'b1001, 32'hFF000000, 0, 1'b0, 0};
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].req, vecs[i].data, vecs[i].exp_id, vecs[i].exp_hit, vecs[i].exp_pos);
         mptr = vecs[i].exp_id;
      end

      for (int n = 0; n < 24; n++) begin
         r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         d = $urandom;
         if (n % 3 == 0) d[((n / 3) % NREQ) * DATA_W +: DATA_W] = 8'hFF >> (n % 5);
         id = modelPick(r, mptr);
         refRun(d[id * DATA_W +: DATA_W], h, pos);
         applyStimulus(r, d, id, h, pos);
         mptr = id;
      end

      // All requesters held: grants must rotate 0,1,2,3,0 with one report each.
      doReset();
      d = 32'h78FFEE0F;
      bus.data = d;
      bus.req  = '1;
      dcount = 0;
      for (int c = 0; c < 120 && dcount < 5; c++) begin
         @(negedge clk);
         if (bus.gnt != '0) gq.push_back(bus.gnt);
         if (bus.done) begin
            dq.push_back(int'(bus.done_id));
            hq.push_back(bus.hit);
            pq.push_back(int'(bus.hit_pos));
            dcount++;
            if (dcount == 5) bus.req = '0;
         end
      end
      bus.req = '0;
      checkOutput("rr_grant_count", 32'(gq.size()), 32'd5);
      checkOutput("rr_done_count", 32'(dq.size()), 32'd5);
      for (int i = 0; i < gq.size() && i < 5; i++)
         checkOutput("rr_grant_order", 32'(gq[i]), 32'(1) << (i % NREQ));
      for (int i = 0; i < dq.size() && i < 5; i++) begin
         refRun(d[(i % NREQ) * DATA_W +: DATA_W], h, pos);
         checkOutput("rr_done_id", 32'(dq[i]), 32'(i % NREQ));
         checkOutput("rr_hit", 32'(hq[i]), 32'(h));
         checkOutput("rr_hit_pos", 32'(pq[i]), 32'(pos));
      end
      repeat (3) @(negedge clk);

      // Reset during SHIFT bit 4 aborts the job silently; pointer returns to its reset value.
      doReset();
      bus.data = 32'h000000F0;
      bus.req  = 4'b0001;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checkOutput("abort_gnt", 32'(bus.gnt), 32'd1);
            bus.req = '0;
         end
      end
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort_gnt_cleared", 32'(bus.gnt), 32'd0);
      checkOutput("abort_busy_cleared", 32'(bus.busy), 32'd0);
      checkOutput("abort_done_low", 32'(bus.done), 32'd0);
      reset = 1'b1;
      dcount = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (bus.done) dcount++;
      end
      checkOutput("abort_no_done", 32'(dcount), 32'd0);
      applyStimulus(4'b0100, 32'h000F0000, 2, 1'b1, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/run_det_sched.md
Name: run_det_sched

Overview:
- Round-robin scheduler sharing one run-of-ones detector among NREQ requesters.
- Each requester presents a DATA_W-bit word. The scheduler grants one requester and shifts that word LSB-first through the shared run detector.
- After the job it reports whether RUN_LEN consecutive 1s occurred, and the bit position where the run first completed.
- Sits between serial-pattern producers and the status/interrupt logic.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DATA_W, 8, bits per job word
- RUN_LEN, 4, consecutive 1s that constitute a hit (1..DATA_W)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req  in  NREQ  per-requester job request, level
- data  in  NREQ*DATA_W  job words, requester i at bits [i*DATA_W +: DATA_W]
- gnt  out  NREQ  one-hot grant, 1-cycle pulse; data[i] is captured in that cycle
- busy  out  1  high from grant through report
- done  out  1  1-cycle pulse, job complete
- done_id  out  clog2(NREQ)  requester index of the completed job
- hit  out  1  run of RUN_LEN 1s found; valid with done
- hit_pos  out  clog2(DATA_W)  bit index where the first run completed; 0 when hit=0

Behaviour:
- Reset (sync, reset==0 at clk edge):
  - state=IDLE; gnt=0, busy=0, done=0, done_id=0, hit=0, hit_pos=0.
  - RR pointer=NREQ-1, so requester 0 has top priority first.
- States: IDLE, LOAD, SHIFT, REPORT; 2-bit encoding from the package.
- IDLE:
  - If any req, pick the first set req[i] searching from pointer+1, wrapping modulo NREQ.
  - Latch the winner index; go to LOAD.
  - No req: stay in IDLE.
- LOAD (1 cycle):
  - gnt[winner]=1, busy=1.
  - Capture data[winner] into the shift register; clear run count, bit count, hit, hit_pos.
  - Go to SHIFT.
  - Requester may drop or change req/data from the next cycle on.
- SHIFT (DATA_W cycles):
  - Current bit = shift_reg[0]; shift right each cycle; bit count 0..DATA_W-1.
  - Run count: +1 on a 1, saturating at RUN_LEN; cleared on a 0.
  - First time run count reaches RUN_LEN: set hit=1 and hit_pos=bit count. Later runs in the same job do not update either.
  - After bit DATA_W-1: go to REPORT.
- REPORT (1 cycle):
  - done=1; done_id, hit and hit_pos are driven together with done.
  - Pointer=winner; go to IDLE; busy=0 from the next cycle.
- Latency: req sampled in IDLE at cycle t -> gnt at t+1 -> bits shifted t+2..t+1+DATA_W -> done at t+2+DATA_W. Back-to-back jobs have one IDLE cycle between them.
- Run count does not carry across jobs or across requesters.
- A req that drops before it is granted is not serviced; there is no queueing.
- New reqs arriving during a job wait; arbitration happens only in IDLE.
- Reset low mid-job: abort; no done for that job; all outputs and the pointer take reset values next edge.
- RUN_LEN=1: a hit occurs on the first 1 bit.

Optional Feature:
- Macro RUN_DET_EARLY_EXIT_EN.
- Defined: SHIFT goes to REPORT on the cycle after the first hit, skipping the remaining bits. done latency = t+3+hit_pos on a hit; t+2+DATA_W otherwise.
- Undefined: all DATA_W bits are always shifted; latency is fixed at t+2+DATA_W.

Decomposition:
- Package run_det_pkg:
  - state enum (IDLE, LOAD, SHIFT, REPORT)
  - RUN_LEN default
  - a clog2 width helper function
- Sub-module run_det_core:
  - serial run counter with inputs clk, reset, clr, en, bit_in; output hit_now.
  - Parameterized by RUN_LEN; a saturating counter replaces a one-hot state chain.
- Top block contains the arbiter, shift register, bit counter and FSM.

Test Plan:
- Single hit (NREQ=4, DATA_W=8, RUN_LEN=4): req=4'b0001, data0=8'h0F at t -> gnt=4'b0001 at t+1; done at t+10 with done_id=0, hit=1, hit_pos=3.
- No hit: data0=8'hEE (runs of 3) -> done at t+10, hit=0, hit_pos=0.
- Multiple runs: data0=8'hFF -> hit=1, hit_pos=3; no second done, hit_pos not updated to 7.
- Round-robin: req=4'b1111 held continuously -> grant order 0,1,2,3,0; exactly one done per grant; done_id matches each grant.
- Mid-job reset: reset=0 during SHIFT bit 4 -> next edge gnt=0, busy=0, done never pulses for the aborted job; next req=4'b0100 is granted to index 2.
- RUN_DET_EARLY_EXIT_EN defined: data0=8'h0F at t -> done at t+6 with hit=1, hit_pos=3; data0=8'h00 -> done at t+10 with hit=0.
